// File: rtl/rr_priority_encoder_pkg.sv
// Shared constants, FSM state type and index/one-hot conversion helpers
// for the round-robin priority encoder.
package rr_priority_encoder_pkg;

    localparam int N_P     = 16;
    localparam int IDX_W_P = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Same mapping as the 4-to-16 decoder; used to build the grant clear mask.
    function automatic logic [N_P-1:0] bin2onehot(input logic [IDX_W_P-1:0] b);
        bin2onehot    = '0;
        bin2onehot[b] = 1'b1;
    endfunction

    function automatic logic [IDX_W_P-1:0] onehot2bin(input logic [N_P-1:0] oh);
        onehot2bin = '0;
        for (int i = 0; i < N_P; i++) begin
            if (oh[i]) begin
                onehot2bin = onehot2bin | IDX_W_P'(i);
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_encoder_select.sv
// Combinational round-robin pick: rotate PEND down by PTR, isolate the lowest
// set bit, convert to binary and rotate the index back up by PTR.
module rr_priority_encoder_select
    import rr_priority_encoder_pkg::*;
(
    input  logic [N_P-1:0]     i_pend,
    input  logic [IDX_W_P-1:0] i_ptr,
    output logic [IDX_W_P-1:0] o_sel,
    output logic               o_any
);

    logic [2*N_P-1:0]   w_dbl;
    logic [N_P-1:0]     w_rot;
    logic [N_P-1:0]     w_first;
    logic [IDX_W_P-1:0] w_rot_idx;

    assign w_dbl     = {i_pend, i_pend} >> i_ptr;
    assign w_rot     = w_dbl[N_P-1:0];
    // Two's-complement trick keeps only the lowest set bit.
    assign w_first   = w_rot & (~w_rot + N_P'(1));
    assign w_rot_idx = onehot2bin(w_first);
    assign o_sel     = w_rot_idx + i_ptr;
    assign o_any     = |i_pend;

endmodule

// File: rtl/rr_priority_encoder.sv
// Collects request pulses into a pending register and hands them out one at a
// time as binary indices over a valid/ready handshake.
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int N     = N_P,
    parameter int IDX_W = IDX_W_P,
    parameter int RR_EN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_in,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [IDX_W-1:0] o_out,
    output logic [N-1:0]     o_pend,
    output logic             o_empty,
    output logic [7:0]       o_coal_cnt
);

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_pend;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_out;
    logic [7:0]       r_coal;

    logic [IDX_W-1:0] w_ptr_eff;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic             w_load;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_dup;
    logic [4:0]       w_dup_cnt;
    logic [8:0]       w_coal_sum;
    logic [7:0]       w_coal_next;

    // Fixed priority is just round-robin with the scan always starting at bit 0.
    assign w_ptr_eff = (RR_EN != 0) ? r_ptr : '0;

    rr_priority_encoder_select u_select (
        .i_pend (r_pend),
        .i_ptr  (w_ptr_eff),
        .o_sel  (w_sel),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load       = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (i_out_ready) begin
                    if (w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_clr = w_load ? bin2onehot(w_sel) : '0;
    // A re-request on the grant edge is not a coalesce: that bit is being cleared.
    assign w_dup = i_in & r_pend & ~w_clr;

    always_comb begin
        w_dup_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_dup_cnt = w_dup_cnt + 5'(w_dup[i]);
        end
    end

    assign w_coal_sum  = {1'b0, r_coal} + 9'(w_dup_cnt);
    assign w_coal_next = w_coal_sum[8] ? 8'hFF : w_coal_sum[7:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_ptr   <= '0;
            r_out   <= '0;
            r_coal  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= (r_pend & ~w_clr) | i_in;
            r_coal  <= w_coal_next;
            if (w_load) begin
                r_out <= w_sel;
                r_ptr <= w_sel + IDX_W'(1);
            end
        end
    end

    assign o_out_valid = (r_state == HOLD);
    assign o_out       = r_out;
    assign o_pend      = r_pend;
    assign o_empty     = (r_pend == '0) && (r_state == IDLE);
    assign o_coal_cnt  = r_coal;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Drives a round-robin and a fixed-priority instance side by side and compares
// both against a queue-level reference model of pending requests and grants.
module tb_rr_priority_encoder;

    logic        clk;
    logic        rst;
    logic [15:0] in_v;
    logic        rdy;

    logic        valid_rr, valid_fx, empty_rr, empty_fx;
    logic [3:0]  out_rr, out_fx;
    logic [15:0] pend_rr, pend_fx;
    logic [7:0]  coal_rr, coal_fx;

    int n_checks;
    int n_fail;

    // Model state; index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [15:0] m_pend[2];
    int          m_ptr[2];
    bit          m_valid[2];
    int          m_out[2];
    int          m_coal[2];

    rr_priority_encoder #(.RR_EN(1)) dut_rr (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_out_ready(rdy),
        .o_out_valid(valid_rr), .o_out(out_rr), .o_pend(pend_rr),
        .o_empty(empty_rr), .o_coal_cnt(coal_rr)
    );

    rr_priority_encoder #(.RR_EN(0)) dut_fx (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_out_ready(rdy),
        .o_out_valid(valid_fx), .o_out(out_fx), .o_pend(pend_fx),
        .o_empty(empty_fx), .o_coal_cnt(coal_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = '0;
            m_ptr[k]   = 0;
            m_valid[k] = 1'b0;
            m_out[k]   = 0;
            m_coal[k]  = 0;
        end
    endtask

    // One clock edge of behaviour for instance k, from the pre-edge state.
    task automatic model_step(input int k, input logic [15:0] req, input logic ready);
        logic [15:0] clr;
        int g;
        int start;
        clr = '0;
        if ((!m_valid[k] || ready) && m_pend[k] != 16'h0) begin
            start = (k == 0) ? m_ptr[k] : 0;
            g = start;
            for (int s = 0; s < 16; s++) begin
                g = (start + s) % 16;
                if (m_pend[k][g]) break;
            end
            m_out[k]   = g;
            m_valid[k] = 1'b1;
            m_ptr[k]   = (g + 1) % 16;
            clr[g]     = 1'b1;
        end else if (m_valid[k] && ready) begin
            m_valid[k] = 1'b0;
        end
        m_coal[k] = m_coal[k] + $countones(req & m_pend[k] & ~clr);
        if (m_coal[k] > 255) m_coal[k] = 255;
        m_pend[k] = (m_pend[k] & ~clr) | req;
    endtask

    task automatic compare_all();
        check("rr_valid", int'(valid_rr), int'(m_valid[0]));
        check("fx_valid", int'(valid_fx), int'(m_valid[1]));
        if (m_valid[0]) check("rr_out", int'(out_rr), m_out[0]);
        if (m_valid[1]) check("fx_out", int'(out_fx), m_out[1]);
        check("rr_pend", int'(pend_rr), int'(m_pend[0]));
        check("fx_pend", int'(pend_fx), int'(m_pend[1]));
        check("rr_coal", int'(coal_rr), m_coal[0]);
        check("fx_coal", int'(coal_fx), m_coal[1]);
        check("rr_empty", int'(empty_rr), int'(m_pend[0] == 16'h0 && !m_valid[0]));
        check("fx_empty", int'(empty_fx), int'(m_pend[1] == 16'h0 && !m_valid[1]));
    endtask

    task automatic cycle(input logic [15:0] req, input logic ready);
        in_v = req;
        rdy  = ready;
        @(posedge clk);
        model_step(0, req, ready);
        model_step(1, req, ready);
        @(negedge clk);
        $display("cyc t=%0t in=%h rdy=%0b rr:v=%0b o=%0d p=%h c=%0d fx:v=%0b o=%0d p=%h c=%0d",
                 $time, req, ready, valid_rr, out_rr, pend_rr, coal_rr,
                 valid_fx, out_fx, pend_fx, coal_fx);
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_rr_valid", int'(valid_rr), 0);
        check("rst_rr_pend", int'(pend_rr), 0);
        check("rst_rr_coal", int'(coal_rr), 0);
        check("rst_rr_empty", int'(empty_rr), 1);
        check("rst_fx_valid", int'(valid_fx), 0);
        check("rst_fx_pend", int'(pend_fx), 0);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        in_v = '0;
        rdy  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_all();
        check("reset_out", int'(out_rr), 0);

        // Reset mid-HOLD with PEND=00F0.
        cycle(16'h0001, 1'b0);
        cycle(16'h0000, 1'b0);
        cycle(16'h00F0, 1'b0);
        check("pre_rst_pend", int'(pend_rr), 16'h00F0);
        async_reset();

        // Single request: index 8 valid for exactly one cycle.
        cycle(16'h0100, 1'b1);
        cycle(16'h0000, 1'b1);
        check("single_out", int'(out_rr), 8);
        cycle(16'h0000, 1'b1);
        check("single_empty", int'(empty_rr), 1);

        // Round-robin sequence 0,5,10,15, then wrap to 0,1.
        async_reset();
        cycle(16'h8421, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0000, 1'b1);
            check("rr_seq", int'(out_rr), i * 5);
        end
        cycle(16'h0003, 1'b1);
        cycle(16'h0000, 1'b1);
        check("rr_wrap0", int'(out_rr), 0);
        cycle(16'h0000, 1'b1);
        check("rr_wrap1", int'(out_rr), 1);
        cycle(16'h0000, 1'b1);

        // Back-pressure: OUT=3 held for 5 cycles while new requests accumulate.
        async_reset();
        cycle(16'h0008, 1'b0);
        cycle(16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(16'h1 << (i + 6), 1'b0);
            check("bp_hold", int'(out_rr), 3);
        end
        check("bp_pend", int'(pend_rr), 16'h07C0);
        repeat (8) cycle(16'h0000, 1'b1);

        // Coalescing, re-request on the grant edge, and saturation.
        async_reset();
        cycle(16'h0001, 1'b0);
        cycle(16'h0004, 1'b0);
        cycle(16'h0004, 1'b0);
        check("coal_one", int'(coal_rr), 1);
        cycle(16'h0004, 1'b1);
        check("regrant_pend", int'(pend_rr), 16'h0004);
        cycle(16'h0000, 1'b1);
        check("regrant_out", int'(out_rr), 2);
        repeat (25) cycle(16'hFFFF, 1'b0);
        check("coal_sat", int'(coal_rr), 255);

        // Fixed priority with all requests held: always bit 0.
        async_reset();
        cycle(16'hFFFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(16'hFFFF, 1'b1);
            check("fx_bit0", int'(out_fx), 0);
        end

        // Randomized traffic with occasional resets.
        async_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cycle(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
            end
        end
        repeat (40) cycle(16'h0000, 1'b1);
        check("drain_empty_rr", int'(empty_rr), 1);
        check("drain_empty_fx", int'(empty_fx), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
